quad_index_counter: RTL and testbench
=====================================

# quad_index_counter

Quadrature front end for the pluto_servo FPGA. Takes raw encoder A/B/Z pins for one axis, synchronizes and glitch-filters them, decodes 4x quadrature into a 14-bit wrapping position count, and latches that count on a qualified index pulse. The EPP register file reads its 28-bit `{index_count, count}` word for each of the four axes.

## Interface
- `FILTER_LEN`, default 4: consecutive stable samples required before a filtered input changes; legal range 1..15.
- `clk`  in  1  system clock, 40 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `quad_a`  in  1  raw encoder A, asynchronous.
- `quad_b`  in  1  raw encoder B, asynchronous.
- `quad_z`  in  1  raw encoder index, asynchronous.
- `z_polarity`  in  1  1 inverts Z before edge detection; static.
- `index_arm`  in  1  single-cycle pulse; arms the index latch and clears `index_valid`.
- `err_clear`  in  1  single-cycle pulse; clears `quad_err`.
- `count`  out  14  position, modulo 2^14.
- `index_count`  out  14  `count` captured at the first armed index edge.
- `index_valid`  out  1  sticky; `index_count` holds a capture.
- `quad_err`  out  1  sticky; an illegal A/B transition occurred.

## Operation
- Each of A, B, Z: 2-flop synchronizer, then filter. Filter counter resets to 0 when synchronized value == filtered value. Otherwise it increments; when it equals FILTER_LEN-1, filtered value takes the synchronized value and the counter clears.
- Decoder compares filtered `{A,B}` with the previous cycle's filtered `{A,B}`:
  - Up sequence 00→10→11→01→00: +1. Reverse sequence: −1.
  - No change: hold.
  - Both bits change: count unchanged; `quad_err` set.
- Count wraps: 0x3FFF+1 = 0x0000 and 0x0000−1 = 0x3FFF. No saturation.
- Index:
  - `zq = filtered Z ^ z_polarity`. Index edge is `zq` 0→1 between consecutive cycles.
  - Internal `armed` is set by `index_arm` and cleared on capture.
  - On an index edge with (`armed` | `index_arm`) in that cycle: `index_count` ← `count` as registered before this cycle's decode update, `index_valid` ← 1, `armed` ← 0.
  - Later index edges are ignored until re-armed.
- `index_arm` with no index edge in the same cycle: `index_valid` ← 0, `armed` ← 1, `index_count` unchanged.
- `err_clear` and an illegal transition in the same cycle: `quad_err` stays 1 (set wins).
- Settle window after reset:
  - For FILTER_LEN+2 cycles after `reset` deasserts, filters load the synchronized value directly with no counting.
  - The decoder and index edge detector only update their previous-value registers during this window; no count change, no error, no capture.
  - This prevents idle-high inputs from producing spurious steps.

## Timing
- Reset values, all outputs: `count`=0, `index_count`=0, `index_valid`=0, `quad_err`=0. Internal `armed`=0; synchronizer and filter registers = 0; settle counter restarted.
- `reset` asserted mid-operation: takes effect at the next edge and discards any pending filter progress.
- Latency, outside the settle window: a pin change sampled at clock edge k updates `count`, `quad_err` or the index capture at edge k+FILTER_LEN+2.
- A pulse shorter than FILTER_LEN cycles at the synchronizer output is rejected.
- Maximum count rate: one step per FILTER_LEN cycles per channel transition, i.e. 10 M steps/s at FILTER_LEN=4.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `pluto_quad_pkg`:
  - `COUNT_W` = 14.
  - Quadrature state constants.
  - Function `quad_step(prev, cur)` returning {inc, dec, err}.
- Sub-module `quad_filter`: synchronizer, filter and settle-load for one pin, parameterized by FILTER_LEN. Instantiated three times (A, B, Z).
- Top module holds the decoder, count, index logic and settle counter.

## Test plan
- Reset, then hold A=B=1 through the settle window → `count` stays 0 and `quad_err` stays 0.
- 8 forward 4x steps (A leads B, 8 cycles per phase), then 3 reverse → `count`=5. From 0, one reverse step → `count`=0x3FFF.
- 3-cycle glitch on A with FILTER_LEN=4 → `count` unchanged. 4-cycle pulse → `count` changes exactly FILTER_LEN+2 edges after the first sampling edge.
- Filtered A and B toggle in the same cycle → `count` held and `quad_err`=1. `err_clear` → `quad_err`=0. `err_clear` coincident with a second illegal transition → `quad_err` stays 1.
- Arm, then move `count` to 0x0123 and pulse Z with `z_polarity`=0 → `index_count`=0x0123, `index_valid`=1. A second Z pulse at 0x0200 leaves `index_count`=0x0123. Re-arm → `index_valid`=0.
- `z_polarity`=1 with Z idle high, falling Z edge at `count`=0x0042 coincident with an up step → `index_count`=0x0042 and `count`=0x0043.

Source files
------------

// File: rtl/pluto_quad_pkg.sv
// Shared widths, quadrature state encodings and the step classifier
// used by the encoder front end.
package pluto_quad_pkg;

  localparam int COUNT_W    = 14;
  localparam int FILT_CNT_W = 4;
  localparam int SETTLE_W   = 5;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  typedef struct packed {
    logic inc;
    logic dec;
    logic err;
  } quad_step_t;

  // Position of an {A,B} pattern along the forward sequence 00->10->11->01.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    logic [1:0] phase;
    case (ab)
      QS_00:   phase = 2'd0;
      QS_10:   phase = 2'd1;
      QS_11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
    return phase;
  endfunction

  function automatic quad_step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    quad_step_t step;
    diff     = quad_phase(cur) - quad_phase(prev);
    step.inc = (diff == 2'd1);
    step.dec = (diff == 2'd3);
    step.err = (diff == 2'd2);
    return step;
  endfunction

endpackage

// File: rtl/quad_index_counter_filter.sv
// Two-flop synchronizer plus stability filter for one encoder pin.
// While i_settle is high the filter tracks the synchronizer with no counting.
module quad_filter
  import pluto_quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_settle,
  input  logic i_pin,
  output logic o_filt
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_LEN - 1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_filt;
  logic [FILT_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // A differing sample must persist FILTER_LEN evaluations before it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (i_settle) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/quad_index_counter.sv
// One-axis quadrature front end: filtered A/B/Z, 4x decode into a wrapping
// position count, and an armed index latch of that count.
module quad_index_counter
  import pluto_quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               quad_a,
  input  logic               quad_b,
  input  logic               quad_z,
  input  logic               z_polarity,
  input  logic               index_arm,
  input  logic               err_clear,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] index_count,
  output logic               index_valid,
  output logic               quad_err
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(FILTER_LEN + 2);

  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [1:0]          r_ab_prev;
  logic                r_zq_prev;
  logic [COUNT_W-1:0]  r_count;
  logic [COUNT_W-1:0]  r_index_count;
  logic                r_index_valid;
  logic                r_armed;
  logic                r_err;

  logic                w_settle;
  logic                w_a;
  logic                w_b;
  logic                w_z;
  logic [1:0]          w_ab;
  logic                w_zq;
  logic                w_index_edge;
  quad_step_t          w_step;

  assign w_settle = (r_settle_cnt != SETTLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle_cnt <= '0;
    end else if (w_settle) begin
      r_settle_cnt <= r_settle_cnt + 1'b1;
    end
  end

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .i_settle(w_settle), .i_pin(quad_a), .o_filt(w_a)
  );
  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .i_settle(w_settle), .i_pin(quad_b), .o_filt(w_b)
  );
  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
    .clk(clk), .reset(reset), .i_settle(w_settle), .i_pin(quad_z), .o_filt(w_z)
  );

  assign w_ab         = {w_a, w_b};
  assign w_zq         = w_z ^ z_polarity;
  assign w_step       = quad_step(r_ab_prev, w_ab);
  assign w_index_edge = w_zq & ~r_zq_prev & ~w_settle;

  // Previous-value registers track even during settle so idle levels never look like edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ab_prev <= 2'b00;
      r_zq_prev <= 1'b0;
    end else begin
      r_ab_prev <= w_ab;
      r_zq_prev <= w_zq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (!w_settle) begin
      if (w_step.inc) begin
        r_count <= r_count + 1'b1;
      end else if (w_step.dec) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // A new illegal transition outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_step.err && !w_settle) begin
      r_err <= 1'b1;
    end else if (err_clear) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index_count <= '0;
      r_index_valid <= 1'b0;
      r_armed       <= 1'b0;
    end else if (w_index_edge && (r_armed || index_arm)) begin
      r_index_count <= r_count;
      r_index_valid <= 1'b1;
      r_armed       <= 1'b0;
    end else if (index_arm) begin
      r_index_valid <= 1'b0;
      r_armed       <= 1'b1;
    end
  end

  assign count       = r_count;
  assign index_count = r_index_count;
  assign index_valid = r_index_valid;
  assign quad_err    = r_err;

endmodule

// File: tb/tb_quad_index_counter.sv
// Self-checking bench for quad_index_counter: directed scenarios plus a
// random walk, all compared against a position-level reference model.
module tb_quad_index_counter;

  localparam int FL   = 4;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        quad_a;
  logic        quad_b;
  logic        quad_z;
  logic        z_polarity;
  logic        index_arm;
  logic        err_clear;
  logic [13:0] count;
  logic [13:0] index_count;
  logic        index_valid;
  logic        quad_err;

  int compared   = 0;
  int mismatched = 0;

  int          mPhase;
  logic [13:0] mCount;
  logic [13:0] mIdxCount;
  logic        mValid;
  logic        mErr;
  logic        mArmed;

  logic [1:0]  ab0;
  logic [1:0]  abG;
  logic [13:0] pulseCount;
  int          delta;
  int          action;
  int          dir;

  quad_index_counter #(.FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b), .quad_z(quad_z),
    .z_polarity(z_polarity), .index_arm(index_arm), .err_clear(err_clear),
    .count(count), .index_count(index_count), .index_valid(index_valid), .quad_err(quad_err)
  );

  always #5 clk = ~clk;

  // Forward sequence position -> {A,B} pin levels.
  function automatic logic [1:0] phasePins(input int p);
    logic [1:0] ab;
    case (p & 3)
      0:       ab = 2'b00;
      1:       ab = 2'b10;
      2:       ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

  function automatic int phaseOf(input logic [1:0] ab);
    int found;
    found = 0;
    for (int p = 0; p < 4; p++) begin
      if (phasePins(p) == ab) found = p;
    end
    return found;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".count"}, 32'(count), 32'(mCount));
    checkOutput({tag, ".quad_err"}, 32'(quad_err), 32'(mErr));
    checkOutput({tag, ".index_count"}, 32'(index_count), 32'(mIdxCount));
    checkOutput({tag, ".index_valid"}, 32'(index_valid), 32'(mValid));
  endtask

  task automatic applyStimulus(input logic [1:0] ab, input logic z, input int hold);
    quad_a = ab[1];
    quad_b = ab[0];
    quad_z = z;
    repeat (hold) @(negedge clk);
  endtask

  task automatic stepQuad(input int d);
    mPhase = (mPhase + d) & 3;
    mCount = (d > 0) ? mCount + 14'd1 : mCount - 14'd1;
    applyStimulus(phasePins(mPhase), quad_z, HOLD);
  endtask

  task automatic moveTo(input logic [13:0] target);
    while (mCount != target) stepQuad(1);
  endtask

  // Capture happens when the polarity-corrected Z goes from inactive to active.
  task automatic setZ(input logic z);
    if (((z ^ z_polarity) == 1'b1) && ((quad_z ^ z_polarity) == 1'b0) && mArmed) begin
      mIdxCount = mCount;
      mValid    = 1'b1;
      mArmed    = 1'b0;
    end
    applyStimulus(phasePins(mPhase), z, HOLD);
  endtask

  task automatic armPulse();
    index_arm = 1'b1;
    @(negedge clk);
    index_arm = 1'b0;
    mArmed = 1'b1;
    mValid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clearPulse();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    mErr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset.count", 32'(count), 32'd0);
    checkOutput("reset.index_count", 32'(index_count), 32'd0);
    checkOutput("reset.index_valid", 32'(index_valid), 32'd0);
    checkOutput("reset.quad_err", 32'(quad_err), 32'd0);
    mCount = '0; mIdxCount = '0; mValid = 1'b0; mErr = 1'b0; mArmed = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < FL + 6; i++) begin
      @(negedge clk);
      checkOutput("settle.count", 32'(count), 32'd0);
      checkOutput("settle.quad_err", 32'(quad_err), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; z_polarity = 1'b0; index_arm = 1'b0; err_clear = 1'b0;
    mPhase = 2;
    quad_a = 1'b1; quad_b = 1'b1; quad_z = 1'b0;
    @(negedge clk);

    doReset();
    checkAll("idle_high");

    for (int i = 0; i < 8; i++) stepQuad(1);
    for (int i = 0; i < 3; i++) stepQuad(-1);
    checkAll("fwd8_rev3");
    checkOutput("fwd8_rev3.literal", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) stepQuad(-1);
    checkAll("back_to_zero");
    stepQuad(-1);
    checkAll("wrap_down");
    checkOutput("wrap_down.literal", 32'(count), 32'h3FFF);
    stepQuad(1);
    checkAll("wrap_up");

    // A 3-cycle glitch on A must vanish; a 4-cycle pulse steps and steps back.
    ab0 = phasePins(mPhase);
    abG = ab0 ^ 2'b10;
    delta = (phaseOf(abG) - mPhase) & 3;
    pulseCount = (delta == 1) ? mCount + 14'd1 : mCount - 14'd1;
    quad_a = abG[1];
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 3) quad_a = ab0[1];
    end
    checkAll("glitch3");
    quad_a = abG[1];
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 4) quad_a = ab0[1];
      if (j == 6) checkOutput("pulse4.before", 32'(count), 32'(mCount));
      if (j == 7) checkOutput("pulse4.at_latency", 32'(count), 32'(pulseCount));
      if (j == 10) checkOutput("pulse4.held", 32'(count), 32'(pulseCount));
      if (j == 11) checkOutput("pulse4.return", 32'(count), 32'(mCount));
    end

    mPhase = (mPhase + 2) & 3;
    mErr = 1'b1;
    applyStimulus(phasePins(mPhase), quad_z, HOLD);
    checkAll("illegal1");
    clearPulse();
    checkAll("err_cleared");
    mPhase = (mPhase + 2) & 3;
    ab0 = phasePins(mPhase);
    quad_a = ab0[1];
    quad_b = ab0[0];
    repeat (FL + 2) @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    mErr = 1'b1;
    repeat (4) @(negedge clk);
    checkAll("illegal_vs_clear");
    clearPulse();

    armPulse();
    checkAll("armed");
    moveTo(14'h0123);
    setZ(1'b1);
    setZ(1'b0);
    checkAll("index_capture");
    checkOutput("index_capture.literal", 32'(index_count), 32'h0123);
    moveTo(14'h0200);
    setZ(1'b1);
    setZ(1'b0);
    checkAll("index_ignored");
    armPulse();
    checkAll("rearm");

    z_polarity = 1'b1;
    quad_z = 1'b1;
    doReset();
    moveTo(14'h0042);
    armPulse();
    mIdxCount = mCount; mValid = 1'b1; mArmed = 1'b0;
    mPhase = (mPhase + 1) & 3;
    mCount = mCount + 14'd1;
    applyStimulus(phasePins(mPhase), 1'b0, HOLD);
    checkAll("z_inv_coincident");
    checkOutput("z_inv_coincident.index_literal", 32'(index_count), 32'h0042);
    checkOutput("z_inv_coincident.count_literal", 32'(count), 32'h0043);
    setZ(1'b1);

    for (int it = 0; it < 150; it++) begin
      action = int'($urandom_range(0, 9));
      if (action <= 6) begin
        dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
        stepQuad(dir);
      end else if (action == 7) begin
        setZ(1'b0);
        setZ(1'b1);
      end else if (action == 8) begin
        armPulse();
      end else begin
        mPhase = (mPhase + 2) & 3;
        mErr = 1'b1;
        applyStimulus(phasePins(mPhase), quad_z, HOLD);
        if ($urandom_range(0, 1) == 1) clearPulse();
      end
      checkAll("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
